dmem_dump_reader: RTL and testbench
===================================

Name: dmem_dump_reader

Overview:
Read-out engine for the data memory of the single-cycle core. It is the reader for the array the program writes. After a start pulse it walks a contiguous word range through a 1-cycle-latency read port. Each word goes out on a valid/ready stream for a bench monitor, UART bridge or debug host. This replaces hierarchical peeks into the memory array.

Parameters:
DATA_W, 32, memory word width in bits
ADDR_W, 8, word-address width; addresses wrap modulo 2^ADDR_W
CNT_W, 9, width of the count input (must hold 2^ADDR_W)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous, active-low reset
start  input  1  one-cycle request to begin a dump; honoured only in IDLE
base_addr  input  ADDR_W  first word address, sampled when start is accepted
count  input  CNT_W  number of words to dump, sampled when start is accepted
busy  output  1  high from the cycle after start is accepted until done
done  output  1  one-cycle pulse when the dump finishes
mem_rd_en  output  1  read strobe to data memory
mem_addr  output  ADDR_W  read address
mem_rd_data  input  DATA_W  read data, valid exactly 1 cycle after mem_rd_en
out_valid  output  1  stream word valid
out_ready  input  1  consumer accepts when out_valid and out_ready are both high
out_data  output  DATA_W  dumped word
out_index  output  CNT_W  0-based position of the word in the dump
out_last  output  1  high with the final word of the dump

Behaviour:
- Reset (rst==0 at posedge): state IDLE. busy, done, mem_rd_en, out_valid and out_last = 0. mem_addr, out_data and out_index = 0. Internal counters cleared. Reset overrides everything, including mid-dump; there is no resume.
- States: IDLE, ISSUE, CAPTURE, SEND, FIN.
- IDLE: on start=1, latch base_addr into addr and count into remaining, and clear the index.
  - count==0: go to FIN, with no memory access.
  - Otherwise go to ISSUE.
  - start=0 keeps the block in IDLE.
- ISSUE: mem_rd_en=1 and mem_addr=addr for exactly this cycle. Next state CAPTURE.
- CAPTURE: register mem_rd_data into out_data. Set out_valid=1 and out_index=index. Set out_last=(remaining==1). Next state SEND.
- SEND: out_valid, out_data, out_index and out_last hold stable until out_valid and out_ready are both high.
  - On acceptance, out_valid drops next cycle. addr increments with modulo wrap, remaining decrements and index increments.
  - Go to FIN if this was the last word, else go to ISSUE.
- FIN: done=1 for one cycle, busy=0, next state IDLE.
- busy=1 in ISSUE, CAPTURE and SEND.
- Latency:
  - First out_valid is 2 cycles after the cycle in which start is sampled.
  - With out_ready held at 1, one word per 3 cycles.
  - done is asserted the cycle after the last handshake.
- start while not in IDLE (including FIN) is ignored. No queueing.
- out_ready while out_valid=0 has no effect.
- Address wrap: addr 2^ADDR_W-1 followed by 0.
- count larger than 2^ADDR_W is legal; addresses repeat.
- mem_rd_en is never asserted outside ISSUE.

Optional Feature:
Macro DUMP_CHECKSUM_EN.
- Defined:
  - Extra output port checksum (output, DATA_W). It is the sum modulo 2^DATA_W of all words accepted in the current dump.
  - It is cleared when start is accepted and updated on each handshake.
  - It is stable and correct in the done cycle and holds until the next accepted start.
  - Reset value 0.
- Undefined: the port and its adder are absent. All other behaviour is identical.

Test Plan:
1. Preload mem[40..59]=20 sorted values 3,7,..; base_addr=40, count=20, out_ready=1 -> 20 words in address order, out_index 0..19, out_last only on index 19, done pulse 1 cycle after the 20th handshake, first out_valid 2 cycles after start.
2. Same dump, out_ready toggling 1 cycle on / 3 cycles off -> out_data and out_index stable while stalled, no word lost or duplicated, exactly 20 mem_rd_en pulses.
3. count=0, start pulse -> done 1 cycle later in FIN, no mem_rd_en, out_valid never high.
4. ADDR_W=8, base_addr=254, count=4 -> mem_addr sequence 254,255,0,1; out_last on the 4th word.
5. Dump in progress, rst=0 for 1 cycle while in SEND -> next cycle IDLE, out_valid=0, busy=0, no done. A start 2 cycles later restarts cleanly from the new base_addr. A start pulse during busy is ignored.
6. With DUMP_CHECKSUM_EN, words 1,2,0xFFFFFFFF -> checksum=2 at done. Without it the build has no checksum port and all other results are identical.

Source files
------------

// File: rtl/dmem_dump_reader.sv
// dmem_dump_reader: walks a contiguous word range of the data memory through a
// 1-cycle-latency read port and streams each word out on a valid/ready port,
// tagged with its 0-based index and a last flag.
// Optional build macro: DUMP_CHECKSUM_EN adds a running modulo-2^DATA_W sum
// of the accepted words on the checksum output.
//
// Stream handshake: a word transfers on a rising edge where out_valid and
// out_ready are both high. Once out_valid rises, out_data, out_index and
// out_last stay stable until that transfer; out_valid never drops without
// one, and out_ready has no effect while out_valid is low.
module dmem_dump_reader #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 8,
    parameter int CNT_W  = 9
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  count,
    output logic              busy,
    output logic              done,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  out_index,
    output logic              out_last,
`ifdef DUMP_CHECKSUM_EN
    output logic [DATA_W-1:0] checksum,
`endif
    output logic [2:0]        dbg_state
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_ISSUE   = 3'd1;
    localparam logic [2:0] S_CAPTURE = 3'd2;
    localparam logic [2:0] S_SEND    = 3'd3;
    localparam logic [2:0] S_FIN     = 3'd4;

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]  remaining_q, remaining_d;
    logic [CNT_W-1:0]  index_q, index_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic [CNT_W-1:0]  out_index_q, out_index_d;
    logic              out_last_q, out_last_d;
    logic              handshake;
    logic              start_ok;

    assign handshake = out_valid_q && out_ready;
    assign start_ok  = (state_q == S_IDLE) && start;

    // Next-state and datapath updates for the dump walk
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        remaining_d = remaining_q;
        index_d     = index_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_index_d = out_index_q;
        out_last_d  = out_last_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    addr_d      = base_addr;
                    remaining_d = count;
                    index_d     = '0;
                    // an empty dump finishes without touching memory
                    state_d     = (count == '0) ? S_FIN : S_ISSUE;
                end
            end
            S_ISSUE: begin
                state_d = S_CAPTURE;
            end
            S_CAPTURE: begin
                out_data_d  = mem_rd_data;
                out_valid_d = 1'b1;
                out_index_d = index_q;
                out_last_d  = (remaining_q == CNT_W'(1));
                state_d     = S_SEND;
            end
            S_SEND: begin
                if (handshake) begin
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                    addr_d      = addr_q + ADDR_W'(1);
                    remaining_d = remaining_q - CNT_W'(1);
                    index_d     = index_q + CNT_W'(1);
                    state_d     = (remaining_q == CNT_W'(1)) ? S_FIN : S_ISSUE;
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers, synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            remaining_q <= '0;
            index_q     <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_index_q <= '0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
            index_q     <= index_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_index_q <= out_index_d;
            out_last_q  <= out_last_d;
        end
    end

`ifdef DUMP_CHECKSUM_EN
    logic [DATA_W-1:0] checksum_q, checksum_d;

    // Running sum: cleared on an accepted start, accumulated on each transfer
    always_comb begin
        checksum_d = checksum_q;
        if (start_ok) begin
            checksum_d = '0;
        end else if ((state_q == S_SEND) && handshake) begin
            checksum_d = checksum_q + out_data_q;
        end
    end

    // Checksum register
    always_ff @(posedge clk) begin
        if (!rst) begin
            checksum_q <= '0;
        end else begin
            checksum_q <= checksum_d;
        end
    end

    assign checksum = checksum_q;
`else
    // Plain build: no running sum is kept.
`endif

    // Outputs decoded from the current state and registers
    assign busy      = (state_q == S_ISSUE) || (state_q == S_CAPTURE) || (state_q == S_SEND);
    assign done      = (state_q == S_FIN);
    assign mem_rd_en = (state_q == S_ISSUE);
    assign mem_addr  = addr_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_index = out_index_q;
    assign out_last  = out_last_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_dmem_dump_reader.sv
// Bench for dmem_dump_reader: a behavioural memory, a stimulus process issuing
// dumps, a ready driver, and a monitor that pops expected words/addresses.
module tb_dmem_dump_reader;

  localparam int DW = 32;
  localparam int AW = 8;
  localparam int CW = 9;
  localparam int W  = 1 + CW + DW;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [CW-1:0] count = '0;
  logic          busy, done, mem_rd_en, out_valid, out_last;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_rd_data = '0;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic [CW-1:0] out_index;
  logic [2:0]    dbg_state;
`ifdef DUMP_CHECKSUM_EN
  logic [DW-1:0] checksum;
`endif

  dmem_dump_reader #(.DATA_W(DW), .ADDR_W(AW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .count(count),
    .busy(busy), .done(done), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
    .mem_rd_data(mem_rd_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_index(out_index), .out_last(out_last),
`ifdef DUMP_CHECKSUM_EN
    .checksum(checksum),
`endif
    .dbg_state(dbg_state)
  );

  // behavioural data memory, 1-cycle read latency
  logic [DW-1:0] mem [256];
  always @(posedge clk) if (mem_rd_en) mem_rd_data <= mem[mem_addr];

  // scoreboard state
  logic [W-1:0]  exp_q[$];
  logic [AW-1:0] addr_exp_q[$];
  int tests_run = 0;
  int fails = 0;
  int cyc = 0;
  int expect_done_cyc = -1;
  int rd_cnt = 0;
  int exp_rd = 0;
  bit dump_active = 0;
  logic [DW-1:0] exp_sum = '0;
  int ready_mode = 0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ready driver: 0 always ready, 1 one-in-four, 2 random, 3 never
  initial begin
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        0: out_ready = 1'b1;
        1: out_ready = (cyc % 4 == 0);
        2: out_ready = 1'($urandom_range(0, 1));
        default: out_ready = 1'b0;
      endcase
    end
  end

  // monitor: compares read addresses, streamed words, stall stability, done
  logic [W-1:0] held = '0;
  bit was_stalled = 0;
  always @(negedge clk) begin
    logic [W-1:0] cur;
    logic [W-1:0] e;
    if (rst) begin
      if (mem_rd_en) begin
        rd_cnt++;
        if (addr_exp_q.size() == 0) begin
          tests_run++; fails++;
          $display("FAIL rd_unexpected: got addr %0d expected no read", mem_addr);
        end else begin
          check("rd_addr", 64'(mem_addr), 64'(addr_exp_q.pop_front()));
        end
      end
      if (exp_q.size() == 0) check("no_valid_without_word", 64'(out_valid), 64'(0));
      if (out_valid) begin
        cur = {out_last, out_index, out_data};
        if (was_stalled) check("stall_stable", 64'(cur), 64'(held));
        held = cur;
        was_stalled = !out_ready;
        if (out_ready && exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("word", 64'(cur), 64'(e));
          if (e[W-1]) expect_done_cyc = cyc + 1;
        end
      end else begin
        was_stalled = 0;
      end
      if (done) begin
        check("done_time", 64'(cyc), 64'(expect_done_cyc));
        check("rd_count", 64'(rd_cnt), 64'(exp_rd));
`ifdef DUMP_CHECKSUM_EN
        check("checksum", 64'(checksum), 64'(exp_sum));
`endif
        dump_active = 0;
        expect_done_cyc = -1;
      end
    end
  end

  // driver: issue one dump and push its reference results
  task automatic do_start(input logic [AW-1:0] b, input int n);
    logic [AW-1:0] a;
    @(posedge clk); #1;
    start = 1'b1; base_addr = b; count = CW'(n);
    rd_cnt = 0; exp_rd = n; exp_sum = '0; dump_active = 1;
    for (int i = 0; i < n; i++) begin
      a = b + AW'(i);
      addr_exp_q.push_back(a);
      exp_q.push_back({(i == n - 1), CW'(i), mem[a]});
      exp_sum = exp_sum + mem[a];
    end
    @(posedge clk); #1;
    start = 1'b0;
    if (n == 0) begin
      expect_done_cyc = cyc;
      check("empty_done", 64'(done), 64'(1));
      check("empty_no_busy", 64'(busy), 64'(0));
      check("empty_no_rd", 64'(mem_rd_en), 64'(0));
    end else begin
      check("issue_busy", 64'(busy), 64'(1));
      check("issue_rd_en", 64'(mem_rd_en), 64'(1));
      @(posedge clk); #1;
      check("capture_no_valid", 64'(out_valid), 64'(0));
      check("capture_no_rd", 64'(mem_rd_en), 64'(0));
      @(posedge clk); #1;
      check("first_valid_latency", 64'(out_valid), 64'(1));
    end
  endtask

  task automatic flush_model();
    exp_q.delete();
    addr_exp_q.delete();
    dump_active = 0;
    expect_done_cyc = -1;
  endtask

  task automatic wait_done(input int limit);
    for (int i = 0; i < limit && dump_active; i++) @(posedge clk);
    if (dump_active) begin
      tests_run++; fails++;
      $display("FAIL dump_timeout: got no done after %0d cycles expected done", limit);
      flush_model();
    end
    @(posedge clk); #1;
    check("after_done_idle_busy", 64'(busy), 64'(0));
    check("after_done_no_done", 64'(done), 64'(0));
  endtask

  // stimulus
  initial begin
    int n;
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_rd_en", 64'(mem_rd_en), 64'(0));
    check("rst_valid", 64'(out_valid), 64'(0));
    check("rst_last", 64'(out_last), 64'(0));
    check("rst_addr", 64'(mem_addr), 64'(0));
    check("rst_data", 64'(out_data), 64'(0));
    check("rst_index", 64'(out_index), 64'(0));
    rst = 1'b1;

    // sorted table, full-rate dump
    for (int i = 0; i < 20; i++) mem[40 + i] = 32'(3 + 4 * i);
    ready_mode = 0;
    do_start(8'd40, 20);
    wait_done(200);

    // same dump with a throttled consumer
    ready_mode = 1;
    do_start(8'd40, 20);
    wait_done(400);

    // empty dump
    ready_mode = 0;
    do_start(8'd7, 0);
    wait_done(20);

    // address wrap
    do_start(8'd254, 4);
    wait_done(50);

    // reset in SEND, ignored start while busy, clean restart
    ready_mode = 3;
    do_start(8'd10, 5);
    start = 1'b1; base_addr = 8'd100; count = 9'd7;
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_start_ignored_valid", 64'(out_valid), 64'(1));
    check("busy_start_ignored_index", 64'(out_index), 64'(0));
    check("busy_start_ignored_data", 64'(out_data), 64'(mem[10]));
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    flush_model();
    check("midrst_valid", 64'(out_valid), 64'(0));
    check("midrst_busy", 64'(busy), 64'(0));
    check("midrst_done", 64'(done), 64'(0));
    check("midrst_index", 64'(out_index), 64'(0));
    ready_mode = 0;
    @(posedge clk);
    do_start(8'd100, 3);
    wait_done(50);

    // count beyond the address space: addresses repeat
    ready_mode = 2;
    do_start(8'd200, 300);
    wait_done(3000);

    // checksum wrap case
    mem[5] = 32'd1; mem[6] = 32'd2; mem[7] = 32'hFFFF_FFFF;
    ready_mode = 0;
    do_start(8'd5, 3);
    wait_done(50);

    // randomized dumps
    for (int k = 0; k < 15; k++) begin
      ready_mode = $urandom_range(0, 2);
      n = $urandom_range(0, 10);
      do_start(AW'($urandom_range(0, 255)), n);
      wait_done(300);
    end

    repeat (4) @(posedge clk);
    #1;
    check("exp_q_drained", 64'(exp_q.size()), 64'(0));
    check("addr_q_drained", 64'(addr_exp_q.size()), 64'(0));
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

  // global watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
